// File: rtl/seg_scan_decoder_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan decoder.
package seg_scan_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  // Lit pattern per hex digit, ordered {a,b,c,d,e,f,g}, 1 = lit
  localparam logic [6:0] GLYPH_TBL [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  localparam logic [6:0] BLANK_PAT = 7'b0000000;

  function automatic logic one_hot_low(input logic [3:0] an);
    return (an == 4'b1110) || (an == 4'b1101) || (an == 4'b1011) || (an == 4'b0111);
  endfunction

endpackage

// File: rtl/seg_scan_decoder_glyph_decode.sv
// Combinational decode of one active-low segment byte {a..g,p} into a hex
// nibble with blank / no-glyph / decimal-point flags.
module seg_glyph_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [7:0] segment,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err,
  output logic       point
);

  logic [6:0] lit;
  logic       hit;

  always_comb begin
    lit    = ~segment[7:1];
    point  = ~segment[0];
    nibble = 4'h0;
    hit    = 1'b0;
    // Glyphs are unique, so at most one entry can match
    for (int k = 0; k < 16; k++) begin
      if (lit == GLYPH_TBL[k]) begin
        nibble = 4'(k);
        hit    = 1'b1;
      end
    end
    blank = (lit == BLANK_PAT);
    err   = !hit && !blank;
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed 4-digit 7-segment scan once per stable dwell and
// publishes a decoded frame after all four digits have been captured.
//
// state     | meaning
// ST_IDLE   | AN is not a single active-low digit select
// ST_SETTLE | digit select seen, counting consecutive stable cycles
// ST_HOLD   | digit sampled, waiting for AN to move on
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  AN,
  input  logic [7:0]  Segment,
  output logic [15:0] hex,
  output logic [3:0]  points,
  output logic [3:0]  blank,
  output logic [3:0]  err,
  output logic        frame_valid,
  output logic        scan_lost
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_TC  = SW'(SETTLE);
  localparam logic [TW-1:0] TIMEOUT_TC = TW'(TIMEOUT);

  state_t        state_q, state_d;
  logic [3:0]    an_q;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          an_one_hot, an_same, sample;

  logic [3:0]    dec_nib;
  logic          dec_blank, dec_err, dec_point;

  logic [15:0]   shd_hex_q, shd_hex_d;
  logic [3:0]    shd_pts_q, shd_pts_d;
  logic [3:0]    shd_blk_q, shd_blk_d;
  logic [3:0]    shd_err_q, shd_err_d;
  logic [3:0]    mask_q, mask_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          lost_d, frame_d;

  assign an_one_hot = one_hot_low(AN);
  assign an_same    = (AN == an_q);

  seg_glyph_decode u_decode (
    .segment (Segment),
    .nibble  (dec_nib),
    .blank   (dec_blank),
    .err     (dec_err),
    .point   (dec_point)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      scnt_q  <= '0;
      an_q    <= 4'hF;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      an_q    <= AN;
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    case (state_q)
      ST_IDLE: begin
        if (an_one_hot) begin
          state_d = ST_SETTLE;
          scnt_d  = SW'(1);
        end
      end
      ST_SETTLE: begin
        if (!an_one_hot) begin
          state_d = ST_IDLE;
          scnt_d  = '0;
        end else if (an_same) begin
          scnt_d  = scnt_q + SW'(1);
        end else begin
          scnt_d  = SW'(1);
        end
      end
      ST_HOLD: begin
        if (!an_one_hot) begin
          state_d = ST_IDLE;
          scnt_d  = '0;
        end else if (!an_same) begin
          state_d = ST_SETTLE;
          scnt_d  = SW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        scnt_d  = '0;
      end
    endcase
    // Terminal count is checked on the incoming value so SETTLE=1 samples at once
    if (state_d == ST_SETTLE && scnt_d >= SETTLE_TC) begin
      state_d = ST_HOLD;
    end
  end

  // A sample is any cycle that lands in HOLD for a new dwell
  always_comb begin
    sample = (state_d == ST_HOLD) && ((state_q != ST_HOLD) || !an_same);
  end

  always_comb begin
    shd_hex_d = shd_hex_q;
    shd_pts_d = shd_pts_q;
    shd_blk_d = shd_blk_q;
    shd_err_d = shd_err_q;
    mask_d    = mask_q;
    tcnt_d    = tcnt_q;
    lost_d    = scan_lost;
    frame_d   = 1'b0;
    if (sample) begin
      for (int i = 0; i < 4; i++) begin
        if (!AN[i]) begin
          shd_hex_d[4*i +: 4] = dec_nib;
          shd_pts_d[i]        = dec_point;
          shd_blk_d[i]        = dec_blank;
          shd_err_d[i]        = dec_err;
          mask_d[i]           = 1'b1;
        end
      end
      tcnt_d = '0;
      lost_d = 1'b0;
    end else if (tcnt_q != TIMEOUT_TC) begin
      tcnt_d = tcnt_q + TW'(1);
      if (tcnt_d == TIMEOUT_TC) begin
        lost_d = 1'b1;
        mask_d = '0;
      end
    end
    if (mask_d == 4'hF) begin
      frame_d = 1'b1;
      mask_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shd_hex_q   <= '0;
      shd_pts_q   <= '0;
      shd_blk_q   <= '0;
      shd_err_q   <= '0;
      mask_q      <= '0;
      tcnt_q      <= '0;
      scan_lost   <= 1'b0;
      frame_valid <= 1'b0;
      hex         <= '0;
      points      <= '0;
      blank       <= '0;
      err         <= '0;
    end else begin
      shd_hex_q   <= shd_hex_d;
      shd_pts_q   <= shd_pts_d;
      shd_blk_q   <= shd_blk_d;
      shd_err_q   <= shd_err_d;
      mask_q      <= mask_d;
      tcnt_q      <= tcnt_d;
      scan_lost   <= lost_d;
      frame_valid <= frame_d;
      if (frame_d) begin
        hex    <= shd_hex_d;
        points <= shd_pts_d;
        blank  <= shd_blk_d;
        err    <= shd_err_d;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a run-length reference model predicts
// per-cycle status and completed frames; a monitor compares them.
module tb_seg_scan_decoder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  AN = 4'hF;
  logic [7:0]  Segment = 8'hFF;
  logic [15:0] hex;
  logic [3:0]  points, blank, err;
  logic        frame_valid, scan_lost;

  seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .AN          (AN),
    .Segment     (Segment),
    .hex         (hex),
    .points      (points),
    .blank       (blank),
    .err         (err),
    .frame_valid (frame_valid),
    .scan_lost   (scan_lost)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fv;
    logic        lost;
    logic [15:0] hex;
    logic [3:0]  pts;
    logic [3:0]  blk;
    logic [3:0]  err;
  } obs_t;

  obs_t cyc_q[$];
  obs_t frm_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;

  localparam logic [6:0] GLYPHS [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  logic [3:0] sel4 [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  // Reference model state: stable-run length, cycles since last sample, captures
  int          run_len;
  logic [3:0]  prev_an;
  int          idle;
  logic [3:0]  mask;
  logic [15:0] sh_hex;
  logic [3:0]  sh_pts, sh_blk, sh_err;
  obs_t        cur;

  function automatic logic [7:0] seg_of(input int k, input bit pt);
    logic [6:0] g;
    g = GLYPHS[k];
    return {~g, ~pt};
  endfunction

  function automatic void decode(input logic [7:0] seg, output logic [3:0] nib,
                                 output bit bk, output bit er, output bit pt);
    logic [6:0] lit;
    bit found = 1'b0;
    lit = ~seg[7:1];
    nib = 4'h0;
    for (int k = 0; k < 16; k++)
      if (GLYPHS[k] == lit) begin nib = 4'(k); found = 1'b1; end
    bk = (lit == 7'd0);
    er = !found && !bk;
    pt = !seg[0];
  endfunction

  function automatic void model_reset();
    run_len = 0; prev_an = 4'hF; idle = 0; mask = 4'h0;
    sh_hex = '0; sh_pts = '0; sh_blk = '0; sh_err = '0;
    cur = '0;
    cyc_q.push_back(cur);
  endfunction

  function automatic void model_step(input logic [3:0] an, input logic [7:0] seg);
    bit oh;
    int d = 0;
    logic [3:0] nib;
    bit bk, er, pt;
    oh = (an == 4'hE) || (an == 4'hD) || (an == 4'hB) || (an == 4'h7);
    if (oh) run_len = (an == prev_an) ? run_len + 1 : 1;
    else    run_len = 0;
    prev_an = an;
    cur.fv = 1'b0;
    if (oh && run_len == SETTLE) begin
      for (int i = 0; i < 4; i++) if (!an[i]) d = i;
      decode(seg, nib, bk, er, pt);
      sh_hex[4*d +: 4] = nib;
      sh_pts[d] = pt; sh_blk[d] = bk; sh_err[d] = er;
      mask[d] = 1'b1;
      idle = 0;
      cur.lost = 1'b0;
    end else if (idle < TIMEOUT) begin
      idle++;
      if (idle == TIMEOUT) begin cur.lost = 1'b1; mask = 4'h0; end
    end
    if (mask == 4'hF) begin
      mask = 4'h0;
      cur.fv = 1'b1;
      cur.hex = sh_hex; cur.pts = sh_pts; cur.blk = sh_blk; cur.err = sh_err;
      frm_q.push_back(cur);
    end
    cyc_q.push_back(cur);
  endfunction

  task automatic drive(input logic [3:0] an, input logic [7:0] seg, input bit rst);
    @(negedge clk);
    rstn = !rst; AN = an; Segment = seg;
    if (rst) model_reset();
    else     model_step(an, seg);
  endtask

  task automatic dwell(input logic [3:0] an, input logic [7:0] seg, input int n);
    repeat (n) drive(an, seg, 1'b0);
  endtask

  task automatic random_phase(input int n);
    int r, k, len;
    logic [3:0] an;
    logic [7:0] seg;
    for (int j = 0; j < n; j++) begin
      r = $urandom_range(0, 99);
      k = $urandom_range(0, 3);
      if (r < 75)      an = sel4[k];
      else if (r < 90) an = 4'($urandom_range(0, 15));
      else             an = 4'hF;
      k = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) seg = 8'($urandom);
      else                           seg = seg_of(k, 1'($urandom));
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 39) == 0) drive(an, seg, 1'b1);
      else if ($urandom_range(0, 19) == 0) dwell(4'hF, seg, $urandom_range(10, 24));
      else dwell(an, seg, len);
    end
  endtask

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor / scoreboard
  initial begin
    obs_t e, f;
    @(negedge clk);
    while (!(done && cyc_q.size() == 0)) begin
      @(posedge clk or negedge rstn);
      #1;
      if (clk == 1'b0) begin
        chk("rst_hex", hex, 16'h0);
        chk("rst_points", 16'(points), 16'h0);
        chk("rst_blank", 16'(blank), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        chk("rst_fv", 16'(frame_valid), 16'h0);
        chk("rst_lost", 16'(scan_lost), 16'h0);
      end else if (cyc_q.size() == 0) begin
        chk("cycle_underflow", 16'(cyc_q.size()), 16'h1);
      end else begin
        e = cyc_q.pop_front();
        chk("frame_valid", 16'(frame_valid), 16'(e.fv));
        chk("scan_lost", 16'(scan_lost), 16'(e.lost));
        chk("hex_hold", hex, e.hex);
        chk("points_hold", 16'(points), 16'(e.pts));
        chk("blank_hold", 16'(blank), 16'(e.blk));
        chk("err_hold", 16'(err), 16'(e.err));
        if (frame_valid === 1'b1) begin
          if (frm_q.size() == 0) begin
            chk("frame_unexpected", 16'(frame_valid), 16'h0);
          end else begin
            f = frm_q.pop_front();
            chk("frame_hex", hex, f.hex);
            chk("frame_points", 16'(points), 16'(f.pts));
            chk("frame_blank", 16'(blank), 16'(f.blk));
            chk("frame_err", 16'(err), 16'(f.err));
          end
        end
      end
    end
    chk("frames_missing", 16'(frm_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    repeat (3) drive(4'hF, 8'hFF, 1'b1);
    // Basic frame: 3,0,A,8 with point on digit 3
    dwell(4'hE, 8'h0D, 10);
    dwell(4'hD, 8'h03, 10);
    dwell(4'hB, 8'h11, 10);
    dwell(4'h7, 8'h00, 10);
    // Toggling faster than SETTLE never samples
    repeat (2) drive(4'hF, 8'hFF, 1'b1);
    repeat (6) begin
      dwell(4'hE, 8'h0D, 3);
      dwell(4'hD, 8'h03, 3);
    end
    // Blank and no-glyph digits
    dwell(4'hE, seg_of(5, 1'b0), 8);
    dwell(4'hD, 8'h91, 8);
    dwell(4'hB, 8'hFF, 8);
    dwell(4'h7, seg_of(12, 1'b1), 8);
    // Non-one-hot selects stay idle
    dwell(4'h0, 8'h00, 50);
    dwell(4'hF, 8'h00, 50);
    // Timeout after three samples, then recovery
    drive(4'hF, 8'hFF, 1'b1);
    dwell(4'hE, seg_of(1, 1'b0), 6);
    dwell(4'hD, seg_of(2, 1'b0), 6);
    dwell(4'hB, seg_of(4, 1'b1), 6);
    dwell(4'hF, 8'hFF, 20);
    dwell(4'hE, seg_of(6, 1'b0), 6);
    dwell(4'hD, seg_of(7, 1'b0), 6);
    dwell(4'hB, seg_of(9, 1'b0), 6);
    dwell(4'h7, seg_of(15, 1'b1), 6);
    // Sample landing exactly on the timeout cycle wins
    dwell(4'hE, seg_of(11, 1'b0), 4);
    dwell(4'hF, 8'hFF, 12);
    dwell(4'hD, seg_of(13, 1'b1), 4);
    dwell(4'hB, seg_of(14, 1'b0), 4);
    dwell(4'h7, seg_of(10, 1'b0), 5);
    // One cycle later the timeout fires first and the capture is lost
    dwell(4'hE, seg_of(3, 1'b0), 4);
    dwell(4'hF, 8'hFF, 13);
    dwell(4'hD, seg_of(8, 1'b0), 4);
    dwell(4'hB, seg_of(0, 1'b0), 5);
    // Reset mid-frame discards captures
    dwell(4'hE, seg_of(1, 1'b1), 5);
    dwell(4'hD, seg_of(2, 1'b1), 5);
    dwell(4'hB, seg_of(3, 1'b1), 2);
    drive(4'hB, seg_of(3, 1'b1), 1'b1);
    dwell(4'hB, seg_of(3, 1'b1), 5);
    dwell(4'h7, seg_of(4, 1'b0), 5);
    dwell(4'hE, seg_of(5, 1'b0), 5);
    dwell(4'hD, seg_of(6, 1'b1), 5);
    dwell(4'hF, 8'hFF, 3);
    random_phase(250);
    dwell(4'hF, 8'hFF, 3);
    done = 1'b1;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE, default 4: consecutive cycles a digit select must stay stable before its segments are sampled.
REQ-002 Parameter TIMEOUT, default 65536: cycles without a sample before the scan is declared lost.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 AN  in  4  digit select, active-low; AN[i]=0 selects digit i.
REQ-006 Segment  in  8  {a,b,c,d,e,f,g,p}, active-low (0 = lit).
REQ-007 hex  out  16  decoded value; nibble hex[4i+3:4i] comes from digit i.
REQ-008 points  out  4  points[i]=1 when p of digit i is lit.
REQ-009 blank  out  4  blank[i]=1 when a..g of digit i are all unlit.
REQ-010 err  out  4  err[i]=1 when a..g of digit i match no hex glyph and are not blank.
REQ-011 frame_valid  out  1  one-cycle pulse; hex/points/blank/err updated on that cycle.
REQ-012 scan_lost  out  1  level; high while no sample has occurred for TIMEOUT cycles.

Function
REQ-013 FSM states: IDLE, SETTLE, HOLD.
- IDLE: AN is not one-hot-low.
- SETTLE: counting stable cycles.
- HOLD: sample taken; waiting for AN to change.
REQ-014 IDLE->SETTLE when AN is one-hot-low; the stable counter loads 1.
REQ-015 SETTLE: AN unchanged increments the counter; on reaching SETTLE, Segment is sampled that cycle and the FSM enters HOLD.
REQ-016 SETTLE: AN changed to another one-hot-low code restarts the counter at 1; a non-one-hot code goes to IDLE without sampling.
REQ-017 HOLD: stays while AN is unchanged (exactly one sample per dwell); on change, goes to SETTLE or IDLE per REQ-014/016.
REQ-018 Sample decode:
- a..g matching hex glyph k gives nibble k, blank=0, err=0.
- All a..g unlit gives nibble 0, blank=1, err=0.
- Otherwise nibble 0, blank=0, err=1.
- Point bit = ~Segment[0], independent of the glyph.
REQ-019 Glyphs (abcdefg, active-high lit): 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011, 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1111011, A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111.
REQ-020 Samples go to a per-digit shadow register and set capture mask bit i; re-sampling a digit before frame completion overwrites it.
REQ-021 Frame completion:
- When the mask reaches 4'b1111, frame_valid pulses on the next cycle.
- On that same cycle the shadow is copied to the outputs and the mask clears.
- Latency: 1 cycle after the fourth sample.
REQ-022 Outputs hold between frames; a partial frame never changes hex/points/blank/err.
REQ-023 Timeout counter behaviour:
- Clears on every sample and saturates at TIMEOUT.
- At TIMEOUT: scan_lost=1 and the capture mask clears.
- scan_lost drops on the cycle after the next sample.
REQ-024 A sample on the same cycle as the timeout is reached takes priority: no scan_lost, mask kept.

Reset
REQ-025 rstn=0 forces, asynchronously: FSM to IDLE; counters, mask, shadow, hex, points, blank, err, frame_valid and scan_lost to 0.
REQ-026 Reset mid-dwell or mid-frame discards the partial frame; the first frame_valid after release requires four fresh samples.

Structure
REQ-027 The shared package holds:
- the 16-entry glyph table (REQ-019);
- the state enumeration;
- the blank pattern constant 7'b0000000.
REQ-028 One sub-module, seg_glyph_decode: combinational mapping of 8-bit Segment to {nibble, blank, err, point}, instantiated once.

Verification
REQ-029 SETTLE=4 scenarios:
- AN 1110/Seg 0x0D, 1101/0x03, 1011/0x11, 0111/0x00, each held 10 cycles -> one frame_valid 1 cycle after the 4th sample, hex=16'h8A03, points=4'b1000, blank=0, err=0.
- AN toggles 1110<->1101 every 3 cycles -> no sample, no frame_valid, outputs stay 0.
- Frame with digit 2 Seg=0xFF and digit 1 Seg=0x91 (abcdefg active-high 0110111, no glyph) -> blank=4'b0100, err=4'b0010, those nibbles 0.
- AN=0000 or 1111 for 50 cycles -> FSM stays IDLE, no sample.
REQ-030 TIMEOUT=16: three digits sampled, then AN=1111 for 20 cycles -> scan_lost=1 16 cycles after the last sample, mask cleared; a full new frame gives frame_valid and scan_lost=0.
REQ-031 rstn pulsed low after two samples -> all outputs 0 immediately; frame_valid appears only after four new samples.
